// File: rtl/demux16_pkg.sv
// Shared widths, state encoding and slot-order constants for the 16:1 deserializer.
// DEMUX16_MSB_FIRST_EN switches slot order from LSB-first to MSB-first.
package demux16_pkg;
  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

`ifdef DEMUX16_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] IDX_FIRST = 4'd15;
  localparam logic [SEL_W-1:0] IDX_LAST  = 4'd0;
`else
  localparam logic [SEL_W-1:0] IDX_FIRST = 4'd0;
  localparam logic [SEL_W-1:0] IDX_LAST  = 4'd15;
`endif
endpackage

// File: rtl/demux1x16_decoder.sv
// 1:16 one-hot slot-write decoder, the structural mirror of the upstream 16:1 mux.
module demux1x16_decoder
  import demux16_pkg::*;
(
  input  logic [SEL_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     we_o
);
  always_comb begin
    we_o = '0;
    if (en_i) we_o[idx_i] = 1'b1;
  end
endmodule

// File: rtl/demux16_deserializer.sv
// Rebuilds a 16-bit word from a qualified serial bit stream (16:1 demux deserializer).
// Optional macro DEMUX16_MSB_FIRST_EN: index counts down from 15, first bit lands in out[15].
module demux16_deserializer
  import demux16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             clear,
  output logic [N-1:0]     out,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);
  localparam logic [SEL_W-1:0] IDX_STEP = 1;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N-1:0]     work_q, work_d;
  logic [N-1:0]     out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     slot_we;

  demux1x16_decoder u_dec (
    .idx_i (idx_q),
    .en_i  (in_valid & ~clear),
    .we_o  (slot_we)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    work_d      = work_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    // clear outranks a bit arriving in the same cycle, including the 16th
    if (clear) begin
      state_d = IDLE;
      idx_d   = IDX_FIRST;
      work_d  = '0;
    end else if (in_valid) begin
      if (idx_q == IDX_LAST) begin
`ifdef DEMUX16_MSB_FIRST_EN
        out_d = {work_q[N-1:1], in};
`else
        out_d = {in, work_q[N-2:0]};
`endif
        out_valid_d = 1'b1;
        work_d      = '0;
        idx_d       = IDX_FIRST;
        state_d     = IDLE;
      end else begin
        work_d = (work_q & ~slot_we) | ({N{in}} & slot_we);
`ifdef DEMUX16_MSB_FIRST_EN
        idx_d = idx_q - IDX_STEP;
`else
        idx_d = idx_q + IDX_STEP;
`endif
        state_d = COLLECT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= IDX_FIRST;
      work_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel       = idx_q;
  assign busy      = (state_q == COLLECT);
endmodule

// File: tb/tb_demux16_deserializer.sv
// Directed bench for demux16_deserializer: table-driven word feeds plus hand-written corner sequences.
module tb_demux16_deserializer;
  import demux16_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in, in_valid, clear;
  logic [15:0] out;
  logic        out_valid;
  logic [3:0]  sel;
  logic        busy;

  always #5 clk = ~clk;

  demux16_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .sel       (sel),
    .busy      (busy)
  );

`ifdef DEMUX16_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  typedef struct {
    logic        in;
    logic        vld;
    logic        clr;
    logic [15:0] exp_out;
    logic        exp_ov;
    logic [3:0]  exp_sel;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // k-th transmitted bit of a word
  function automatic logic bit_at(input logic [15:0] w, input int k);
    return MSB ? w[15-k] : w[k];
  endfunction

  // sel after n bits of a word have been accepted (n=16 wraps to the start slot)
  function automatic logic [3:0] sel_after(input int n);
    return MSB ? 4'(15 - n) : 4'(n);
  endfunction

  function automatic vec_t mk(input logic i, input logic v, input logic c, input logic [15:0] eo,
                              input logic ov, input logic [3:0] es, input logic eb);
    vec_t r;
    r.in = i; r.vld = v; r.clr = c; r.exp_out = eo; r.exp_ov = ov; r.exp_sel = es; r.exp_busy = eb;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_word(input logic [15:0] w, input bit clr_last, input int nbits,
                           output int pulses, output logic [15:0] pulse_out);
    pulses    = 0;
    pulse_out = '0;
    for (int k = 0; k < nbits; k++) begin
      in       = bit_at(w, k);
      in_valid = 1'b1;
      clear    = clr_last && (k == 15);
      tick();
      if (out_valid) begin
        pulses++;
        pulse_out = out;
      end
    end
    in       = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    int          pulses;
    logic [15:0] pout;
    int          pc [2];
    logic [15:0] po [2];
    int          np;
    logic [15:0] w;

    rst = 1'b1; in = 1'b0; in_valid = 1'b0; clear = 1'b0;
    repeat (2) tick();
    check("reset_out", 32'(out), 32'h0);
    check("reset_ov", 32'(out_valid), 32'h0);
    check("reset_sel", 32'(sel), 32'(sel_after(0)));
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // plain word feed, then the same word with idle gaps after bits 2, 7 and 14
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(bit_at(16'h3F0A, k), 1'b1, 1'b0, (k == 15) ? 16'h3F0A : 16'h0000,
                       k == 15, sel_after(k + 1), k != 15));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h3F0A, 1'b0, sel_after(0), 1'b0));
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(mk(bit_at(16'h3F0A, k), 1'b1, 1'b0, 16'h3F0A, k == 15, sel_after(k + 1), k != 15));
      if (k == 1 || k == 6 || k == 13)
        repeat (3) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h3F0A, 1'b0, sel_after(k + 1), 1'b1));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h3F0A, 1'b0, sel_after(0), 1'b0));

    foreach (tbl[i]) begin
      in = tbl[i].in; in_valid = tbl[i].vld; clear = tbl[i].clr;
      tick();
      check($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].exp_sel));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end
    in_valid = 1'b0;

    // back-to-back words with no bubble
    np = 0;
    pc[0] = -1; pc[1] = -1; po[0] = '0; po[1] = '0;
    for (int c = 0; c < 32; c++) begin
      w        = (c < 16) ? 16'h3F0A : 16'hC5F0;
      in       = bit_at(w, c % 16);
      in_valid = 1'b1;
      tick();
      if (out_valid) begin
        if (np < 2) begin
          pc[np] = c;
          po[np] = out;
        end
        np++;
      end
    end
    in_valid = 1'b0;
    check("b2b_pulses", 32'(np), 32'd2);
    check("b2b_cycle1", 32'(pc[0]), 32'd15);
    check("b2b_cycle2", 32'(pc[1]), 32'd31);
    check("b2b_out1", 32'(po[0]), 32'h3F0A);
    check("b2b_out2", 32'(po[1]), 32'hC5F0);

    // clear after 6 bits, with a bit offered in the clear cycle
    feed_word(16'hFFFF, 1'b0, 6, pulses, pout);
    check("clr_pre_pulses", 32'(pulses), 32'd0);
    check("clr_pre_sel", 32'(sel), 32'(sel_after(6)));
    check("clr_pre_busy", 32'(busy), 32'h1);
    in = 1'b1; in_valid = 1'b1; clear = 1'b1;
    tick();
    in = 1'b0; in_valid = 1'b0; clear = 1'b0;
    check("clr_sel", 32'(sel), 32'(sel_after(0)));
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_ov", 32'(out_valid), 32'h0);
    check("clr_out", 32'(out), 32'hC5F0);
    feed_word(16'hA5A5, 1'b0, 16, pulses, pout);
    check("clr_word_pulses", 32'(pulses), 32'd1);
    check("clr_word_out", 32'(pout), 32'hA5A5);

    // clear on the 16th bit suppresses completion
    feed_word(16'h0F0F, 1'b1, 16, pulses, pout);
    check("clr16_pulses", 32'(pulses), 32'd0);
    check("clr16_out", 32'(out), 32'hA5A5);
    check("clr16_sel", 32'(sel), 32'(sel_after(0)));
    check("clr16_busy", 32'(busy), 32'h0);

    // reset after 9 bits
    feed_word(16'hFFFF, 1'b0, 9, pulses, pout);
    check("rst_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_out", 32'(out), 32'h0);
    check("rst_sel", 32'(sel), 32'(sel_after(0)));
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ov", 32'(out_valid), 32'h0);
    feed_word(16'h1234, 1'b0, 16, pulses, pout);
    check("rst_word_pulses", 32'(pulses), 32'd1);
    check("rst_word_out", 32'(pout), 32'h1234);
    tick();
    check("rst_word_ov_drop", 32'(out_valid), 32'h0);
    check("rst_word_hold", 32'(out), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
